cas_arbiter: RTL and testbench
==============================

Name: cas_arbiter

Overview:
- Arbitrates between the read and write CAS requesters of the memory controller.
- Issues one CAS per grant toward the read/write data-timing controller (cas_rdy / cas_req).
- Enforces same-direction spacing (tCCD) and read/write turnaround gaps.
- Prefers reads, with a write-starvation guard. Sits between the bank/command scheduler and the data-timing controller.

Parameters:
- STARVE_MAX, 8: consecutive read grants allowed while a write is pending before reads are blocked.
- GAP_W, 6: width of the gap counter and the turnaround inputs.

Ports:
- CK_t  in  1  controller clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cas_en  in  1  1 = CAS issue permitted; 0 = hold, e.g. during refresh.
- ccd_gap  in  4  min cycles between same-direction CAS; values <2 are treated as 2.
- wr2rd_gap  in  GAP_W  min cycles from a write CAS to the next read CAS.
- rd2wr_gap  in  GAP_W  min cycles from a read CAS to the next write CAS.
- rd_req  in  1  read request pending; held until rd_gnt is seen.
- rd_ap  in  1  read carries auto-precharge.
- wr_req  in  1  write request pending; held until wr_gnt is seen.
- wr_ap  in  1  write carries auto-precharge.
- rd_gnt  out  1  one-cycle read grant pulse.
- wr_gnt  out  1  one-cycle write grant pulse.
- cas_rdy  out  1  one-cycle CAS issue strobe, coincident with either grant.
- cas_req  out  2  {is_read, auto_precharge}; valid while cas_rdy=1.
- starving  out  1  1 while in ARB_WR_FORCE.

Behaviour:
- Async reset state:
  - All outputs 0.
  - state=ARB_IDLE, last_dir=READ.
  - gap_cnt saturated at all-ones; starve_cnt=0.
- gap_cnt:
  - Loaded with 1 on each edge where a CAS is issued.
  - Otherwise increments each edge, saturating at 2^GAP_W-1.
- Eligibility, evaluated combinationally from registered state and current inputs:
  - rd_ok = rd_req & cas_en & state!=ARB_WR_FORCE & (state==ARB_IDLE | gap_cnt >= (last_dir==READ ? eff_ccd : wr2rd_gap)).
  - wr_ok = wr_req & cas_en & (state==ARB_IDLE | gap_cnt >= (last_dir==WRITE ? eff_ccd : rd2wr_gap)).
  - eff_ccd = max(ccd_gap, 2).
- Selection:
  - rd_ok wins; else wr_ok wins.
  - ARB_WR_FORCE masks rd_ok, so a pending write always eventually issues once its gap is met.
- Outputs are registered:
  - A decision at edge k drives gnt/cas_rdy/cas_req high for exactly the cycle following edge k.
  - Latency from an eligible request to the grant is one clock.
  - Requesters drop req (or present the next request) in the cycle gnt is high.
  - eff_ccd >= 2 guarantees no double grant on a held request.
- starve_cnt:
  - Increments on a read grant while wr_req=1.
  - Clears on a write grant or whenever wr_req=0.
  - Saturates at STARVE_MAX.
- States:
  - ARB_IDLE (after reset only): read grant -> ARB_RD; write grant -> ARB_WR.
  - ARB_RD: write grant -> ARB_WR; starve_cnt reaching STARVE_MAX on a read grant -> ARB_WR_FORCE.
  - ARB_WR: read grant -> ARB_RD.
  - ARB_WR_FORCE: write grant -> ARB_WR; wr_req=0 -> ARB_RD (starve_cnt cleared).
  - last_dir updates with every grant.
- cas_en=0:
  - No grants; gap_cnt keeps counting.
  - Requests stay pending; state unchanged.
- Simultaneous rd_req/wr_req both eligible: the read is granted, except in ARB_WR_FORCE.
- Request withdrawn before a grant: legal; no grant is produced.
- Gap inputs are sampled live; software changes them only while no requests are pending.
- Reset mid-operation: an in-flight gnt/cas_rdy pulse is cleared immediately; post-reset behaviour is as ARB_IDLE.

Test Plan:
- Reset, then rd_req=1 with rd_ap=0 at cycle 2 -> rd_gnt=cas_rdy=1 at cycle 3, cas_req=2'b10; no further grant.
- Back-to-back reads, ccd_gap=4, rd_req held and re-asserted after each grant -> cas_rdy at cycles n, n+4, n+8 exactly.
- Read then write, rd2wr_gap=7 -> wr_gnt exactly 7 cycles after rd_gnt; wr_req ignored before then. Repeat write->read with wr2rd_gap=12 -> 12-cycle spacing.
- Continuous reads with wr_req=1, STARVE_MAX=8, ccd_gap=4, rd2wr_gap=7:
  - After the 8th read grant, starving=1 and reads are blocked.
  - wr_gnt arrives 7 cycles after the 8th read; starving then drops.
- cas_en=0 for 20 cycles with both requests pending -> no grants; on cas_en=1 the read is granted next cycle (gap already met). Then set ccd_gap=1 -> spacing is 2 cycles.
- Assert reset_n=0 in the same cycle wr_gnt is high -> wr_gnt, cas_rdy and starving drop immediately; after release, the first eligible request is granted with no gap wait.

Source files
------------

// File: rtl/cas_arbiter.sv
// Read/write CAS arbiter: picks one CAS per grant, enforcing tCCD and turnaround
// gaps, preferring reads while guarding writes against starvation.
module cas_arbiter #(
  parameter int STARVE_MAX = 8,
  parameter int GAP_W      = 6
) (
  input  logic             CK_t,
  input  logic             reset_n,
  input  logic             cas_en,
  input  logic [3:0]       ccd_gap,
  input  logic [GAP_W-1:0] wr2rd_gap,
  input  logic [GAP_W-1:0] rd2wr_gap,
  input  logic             rd_req,
  input  logic             rd_ap,
  input  logic             wr_req,
  input  logic             wr_ap,
  output logic             rd_gnt,
  output logic             wr_gnt,
  output logic             cas_rdy,
  output logic [1:0]       cas_req,
  output logic             starving,
  output logic [1:0]       arb_state
);

  // Handshake: a requester holds req until it sees its one-cycle gnt pulse; in
  // that gnt cycle it drops req or presents the next request. cas_req is valid
  // only while cas_rdy=1.

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_RD       = 2'd1,
    ARB_WR       = 2'd2,
    ARB_WR_FORCE = 2'd3
  } arb_state_e;

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e       state, state_nxt;
  logic [SW-1:0]    starve_cnt, starve_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_rd;

  logic [3:0]       eff_ccd4;
  logic [GAP_W-1:0] eff_ccd;
  logic [GAP_W-1:0] rd_lim, wr_lim;
  logic             rd_ok, wr_ok, rd_sel, wr_sel, cas_issue, starve_hit;

  assign eff_ccd4 = (ccd_gap < 4'd2) ? 4'd2 : ccd_gap;
  assign eff_ccd  = GAP_W'(eff_ccd4);

  // The required gap depends on whether the next CAS keeps or flips direction.
  assign rd_lim = last_rd ? eff_ccd : wr2rd_gap;
  assign wr_lim = last_rd ? rd2wr_gap : eff_ccd;

  assign rd_ok = rd_req & cas_en & (state != ARB_WR_FORCE) &
                 ((state == ARB_IDLE) | (gap_cnt >= rd_lim));
  assign wr_ok = wr_req & cas_en &
                 ((state == ARB_IDLE) | (gap_cnt >= wr_lim));

  assign rd_sel     = rd_ok;
  assign wr_sel     = wr_ok & ~rd_ok;
  assign cas_issue  = rd_sel | wr_sel;
  assign starve_hit = rd_sel & wr_req & (starve_cnt >= SW'(STARVE_MAX - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE, ARB_RD, ARB_WR: begin
        if (rd_sel)      state_nxt = starve_hit ? ARB_WR_FORCE : ARB_RD;
        else if (wr_sel) state_nxt = ARB_WR;
      end
      ARB_WR_FORCE: begin
        if (wr_sel)       state_nxt = ARB_WR;
        else if (!wr_req) state_nxt = ARB_RD;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (wr_sel || !wr_req)
      starve_nxt = '0;
    else if (rd_sel && (starve_cnt < SW'(STARVE_MAX)))
      starve_nxt = starve_cnt + SW'(1);
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      gap_cnt    <= '1;
      last_rd    <= 1'b1;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (cas_issue) begin
        gap_cnt <= GAP_W'(1);
        last_rd <= rd_sel;
      end else if (gap_cnt != '1) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

  // Grant outputs are registered so the pulse occupies the cycle after the decision.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      rd_gnt  <= 1'b0;
      wr_gnt  <= 1'b0;
      cas_rdy <= 1'b0;
      cas_req <= 2'b00;
    end else begin
      rd_gnt  <= rd_sel;
      wr_gnt  <= wr_sel;
      cas_rdy <= cas_issue;
      if (rd_sel)      cas_req <= {1'b1, rd_ap};
      else if (wr_sel) cas_req <= {1'b0, wr_ap};
      else             cas_req <= 2'b00;
    end
  end

  assign starving  = (state == ARB_WR_FORCE);
  assign arb_state = state;

endmodule

// File: tb/tb_cas_arbiter.sv
// Bench for cas_arbiter: fixed vector table, directed timing sequences and a
// randomized run against a cycle-count based reference model.
module tb_cas_arbiter;
  localparam int STARVE_MAX = 8;
  localparam int GAP_W      = 6;
  localparam int SAT        = 63;

  logic             CK_t, reset_n, cas_en;
  logic [3:0]       ccd_gap;
  logic [GAP_W-1:0] wr2rd_gap, rd2wr_gap;
  logic             rd_req, rd_ap, wr_req, wr_ap;
  logic             rd_gnt, wr_gnt, cas_rdy, starving;
  logic [1:0]       cas_req, arb_state;

  cas_arbiter #(.STARVE_MAX(STARVE_MAX), .GAP_W(GAP_W)) dut (
    .CK_t(CK_t), .reset_n(reset_n), .cas_en(cas_en), .ccd_gap(ccd_gap),
    .wr2rd_gap(wr2rd_gap), .rd2wr_gap(rd2wr_gap), .rd_req(rd_req), .rd_ap(rd_ap),
    .wr_req(wr_req), .wr_ap(wr_ap), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
    .cas_rdy(cas_rdy), .cas_req(cas_req), .starving(starving), .arb_state(arb_state)
  );

  // clock / watchdog
  initial CK_t = 1'b0;
  always #5 CK_t = ~CK_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];

  // reference model: time since last CAS, its direction, read streak, force flag
  bit m_idle, m_force, m_last_rd;
  int m_since, m_starve;

  task automatic model_reset();
    m_idle = 1; m_force = 0; m_last_rd = 1; m_since = SAT; m_starve = 0;
  endtask

  task automatic model_edge(output logic [5:0] e);
    int eff, rlim, wlim;
    bit rok, wok, rs, ws;
    logic [1:0] req;
    eff  = (ccd_gap < 2) ? 2 : int'(ccd_gap);
    rlim = m_last_rd ? eff : int'(wr2rd_gap);
    wlim = m_last_rd ? int'(rd2wr_gap) : eff;
    rok  = rd_req && cas_en && !m_force && (m_idle || m_since >= rlim);
    wok  = wr_req && cas_en && (m_idle || m_since >= wlim);
    rs   = rok;
    ws   = !rok && wok;
    if (ws || !wr_req) m_starve = 0;
    else if (rs && m_starve < STARVE_MAX) m_starve++;
    if (ws) m_force = 0;
    else if (m_force && !wr_req) m_force = 0;
    else if (rs && wr_req && m_starve == STARVE_MAX) m_force = 1;
    if (rs || ws) begin
      m_since = 1; m_last_rd = rs; m_idle = 0;
    end else if (m_since < SAT) begin
      m_since++;
    end
    req = rs ? {1'b1, rd_ap} : (ws ? {1'b0, wr_ap} : 2'b00);
    e = {rs, ws, rs | ws, req, m_force};
  endtask

  function automatic logic [5:0] dut_out();
    return {rd_gnt, wr_gnt, cas_rdy, cas_req, starving};
  endfunction

  task automatic check_vec(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (rd,wr,rdy,req[1:0],starving) t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d t=%0t", name, act, exp, $time);
    end
  endtask

  // driver: one clock edge, model predicts, scoreboard compares #1 after the edge
  task automatic step();
    logic [5:0] e;
    model_edge(e);
    exp_q.push_back(e);
    @(posedge CK_t);
    #1;
    check_vec("model", dut_out(), exp_q.pop_front());
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rd_req = 0; wr_req = 0; rd_ap = 0; wr_ap = 0; cas_en = 1;
    model_reset();
    repeat (2) @(posedge CK_t);
    @(negedge CK_t);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic cas_en, rd_req, rd_ap, wr_req, wr_ap;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[14];

  task automatic set_vec(input int i, input logic en, input logic rq, input logic ra,
                         input logic wq, input logic wa, input logic [5:0] ex);
    vecs[i].cas_en = en; vecs[i].rd_req = rq; vecs[i].rd_ap = ra;
    vecs[i].wr_req = wq; vecs[i].wr_ap = wa; vecs[i].exp = ex;
  endtask

  initial begin
    int rd_t[$];
    int wr_t, st_at8, st_atw, last_r, sp, cnt, i0;

    // ccd=2, wr2rd=3, rd2wr=3 for the table
    set_vec(0,  1, 1, 0, 0, 0, 6'b101100);
    set_vec(1,  1, 0, 0, 0, 0, 6'b000000);
    set_vec(2,  1, 0, 0, 1, 1, 6'b000000);
    set_vec(3,  1, 0, 0, 1, 1, 6'b011010);
    set_vec(4,  1, 1, 1, 0, 0, 6'b000000);
    set_vec(5,  1, 1, 1, 0, 0, 6'b000000);
    set_vec(6,  1, 1, 1, 0, 0, 6'b101110);
    set_vec(7,  1, 1, 0, 1, 0, 6'b000000);
    set_vec(8,  1, 1, 0, 1, 0, 6'b101100);
    set_vec(9,  0, 0, 0, 1, 0, 6'b000000);
    set_vec(10, 0, 0, 0, 1, 0, 6'b000000);
    set_vec(11, 0, 0, 0, 1, 0, 6'b000000);
    set_vec(12, 1, 0, 0, 1, 0, 6'b011000);
    set_vec(13, 1, 0, 0, 0, 0, 6'b000000);

    reset_n = 1'b0; cas_en = 1; rd_req = 0; rd_ap = 0; wr_req = 0; wr_ap = 0;
    ccd_gap = 4'd2; wr2rd_gap = 6'd3; rd2wr_gap = 6'd3;
    model_reset();
    repeat (2) @(posedge CK_t);
    #1;
    check_vec("reset_out", dut_out(), 6'b000000);
    check_int("reset_state", int'(arb_state), 0);
    @(negedge CK_t);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cas_en = vecs[i].cas_en; rd_req = vecs[i].rd_req; rd_ap = vecs[i].rd_ap;
      wr_req = vecs[i].wr_req; wr_ap = vecs[i].wr_ap;
      step();
      check_vec($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

    // back-to-back reads, ccd=4
    do_reset();
    ccd_gap = 4'd4;
    rd_req = 1;
    rd_t.delete();
    for (int i = 0; i < 14; i++) begin
      step();
      if (rd_gnt) rd_t.push_back(i);
    end
    check_int("ccd_count", rd_t.size(), 4);
    if (rd_t.size() >= 3) begin
      check_int("ccd_sp1", rd_t[1] - rd_t[0], 4);
      check_int("ccd_sp2", rd_t[2] - rd_t[1], 4);
    end else begin
      check_int("ccd_grants", rd_t.size(), 3);
    end

    // read->write 7, write->read 12
    do_reset();
    ccd_gap = 4'd4; rd2wr_gap = 6'd7; wr2rd_gap = 6'd12;
    rd_req = 1;
    step();
    check_vec("rw_first_rd", dut_out(), 6'b101100);
    rd_req = 0; wr_req = 1; wr_ap = 1;
    sp = -1;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (wr_gnt) begin sp = j; break; end
    end
    check_int("rd2wr_spacing", sp, 7);
    wr_req = 0; rd_req = 1;
    sp = -1;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (rd_gnt) begin sp = j; break; end
    end
    check_int("wr2rd_spacing", sp, 12);
    rd_req = 0;
    step();

    // write starvation guard
    do_reset();
    ccd_gap = 4'd4; rd2wr_gap = 6'd7; wr2rd_gap = 6'd4;
    rd_req = 1; wr_req = 1; wr_ap = 0;
    rd_t.delete(); wr_t = -1; st_at8 = -1; st_atw = -1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (rd_gnt) begin
        rd_t.push_back(i);
        if (rd_t.size() == 8) st_at8 = int'(starving);
      end
      if (wr_gnt) begin wr_t = i; st_atw = int'(starving); break; end
    end
    last_r = (rd_t.size() > 0) ? rd_t[rd_t.size()-1] : -100;
    check_int("starve_reads", rd_t.size(), 8);
    check_int("starve_flag", st_at8, 1);
    check_int("starve_wr_gap", wr_t - last_r, 7);
    check_int("starve_drop", st_atw, 0);
    rd_req = 0; wr_req = 0;
    step();

    // cas_en hold with both pending, then ccd below 2
    do_reset();
    ccd_gap = 4'd4; rd2wr_gap = 6'd3; wr2rd_gap = 6'd3;
    rd_req = 1; wr_req = 1; cas_en = 0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cas_rdy) cnt++;
    end
    check_int("hold_no_grant", cnt, 0);
    cas_en = 1;
    step();
    check_vec("hold_resume", dut_out(), 6'b101100);
    ccd_gap = 4'd1;
    sp = -1;
    for (int j = 1; j <= 10; j++) begin
      step();
      if (rd_gnt) begin sp = j; break; end
    end
    check_int("ccd_min2", sp, 2);
    rd_req = 0; wr_req = 0;
    step();

    // reset while wr_gnt is high
    do_reset();
    wr_req = 1; wr_ap = 1;
    step();
    check_vec("pre_rst_wr", dut_out(), 6'b011010);
    reset_n = 1'b0;
    #1;
    check_vec("mid_reset", dut_out(), 6'b000000);
    wr_req = 0;
    model_reset();
    @(posedge CK_t);
    @(negedge CK_t);
    reset_n = 1'b1;
    rd2wr_gap = 6'd40; wr2rd_gap = 6'd40;
    rd_req = 1; rd_ap = 0;
    step();
    check_vec("post_reset_rd", dut_out(), 6'b101100);
    rd_req = 0;
    step();

    // randomized traffic against the model
    do_reset();
    ccd_gap = 4'd3; rd2wr_gap = 6'd5; wr2rd_gap = 6'd6;
    for (int i = 0; i < 3000; i++) begin
      cas_en = ($urandom_range(0, 9) != 0);
      if (rd_gnt || !rd_req) begin
        rd_req = ($urandom_range(0, 2) == 0);
        rd_ap  = 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 49) == 0) begin
        rd_req = 0;
      end
      if (wr_gnt || !wr_req) begin
        wr_req = ($urandom_range(0, 3) == 0);
        wr_ap  = 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 49) == 0) begin
        wr_req = 0;
      end
      if (!rd_req && !wr_req && $urandom_range(0, 7) == 0) begin
        ccd_gap   = 4'($urandom_range(0, 7));
        wr2rd_gap = GAP_W'($urandom_range(0, 15));
        rd2wr_gap = GAP_W'($urandom_range(0, 15));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
